// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : axis_sync_fifo
// Brief   : Single-clock AXI-Stream FIFO with registered ready/valid/count.
//           Define AXIS_FIFO_PROTOCOL_CHECK_EN to compile protocol assertions.
// Revision: 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
  parameter int TDATA_BYTES = 1,
  parameter int DEPTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [TDATA_BYTES*8-1:0]    s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [TDATA_BYTES*8-1:0]    m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int DW = TDATA_BYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("axis_sync_fifo: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = m_axis_tvalid & m_axis_tready;

  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
  end

  // Flags are computed from the next count so a word is never held back a cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count         <= count_next;
      m_axis_tvalid <= (count_next != '0);
      s_axis_tready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn && push) mem[wr_ptr] <= s_axis_tdata;
  end

  assign m_axis_tdata = mem[rd_ptr];

`ifdef AXIS_FIFO_PROTOCOL_CHECK_EN
  a_s_axis_hold: assert property (@(posedge aclk) disable iff (!aresetn)
    (s_axis_tvalid && !s_axis_tready) |=> (s_axis_tvalid && $stable(s_axis_tdata)))
    else $error("a_s_axis_hold");

  a_m_axis_hold: assert property (@(posedge aclk) disable iff (!aresetn)
    (m_axis_tvalid && !m_axis_tready) |=> (m_axis_tvalid && $stable(m_axis_tdata)))
    else $error("a_m_axis_hold");

  a_count_range: assert property (@(posedge aclk) disable iff (!aresetn)
    count <= CW'(DEPTH))
    else $error("a_count_range");

  a_no_push_full: assert property (@(posedge aclk) disable iff (!aresetn)
    (count == CW'(DEPTH)) |-> !push)
    else $error("a_no_push_full");

  a_no_pop_empty: assert property (@(posedge aclk) disable iff (!aresetn)
    (count == '0) |-> !pop)
    else $error("a_no_pop_empty");
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_sync_fifo
// Brief   : Self-checking bench for axis_sync_fifo (vector table, corner
//           sequences, random traffic against a queue reference model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_axis_sync_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_q [$];

  axis_sync_fifo #(.TDATA_BYTES(1), .DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .count         (count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic       tvalid;
    logic [7:0] tdata;
    logic       mready;
    int         exp_count;
    logic       exp_mvalid;
    logic       exp_sready;
    logic [7:0] exp_mdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Outputs sampled 1 time unit after an edge are compared with the queue model.
  task automatic chk_model(input string tag);
    chk({tag, "_count"},  32'(count),         32'(model_q.size()));
    chk({tag, "_mvalid"}, 32'(m_axis_tvalid), 32'(model_q.size() != 0));
    chk({tag, "_sready"}, 32'(s_axis_tready), 32'(model_q.size() < DEPTH));
    if (model_q.size() != 0) chk({tag, "_mdata"}, 32'(m_axis_tdata), 32'(model_q[0]));
  endtask

  task automatic run_traffic(input string tag, input int nwords, input bit throttle);
    int sent = 0, rcvd = 0, cycles = 0, wgap = 0, rgap = 0;
    bit do_push, do_pop;
    s_axis_tvalid = 1'b0;
    while (rcvd < nwords && cycles < 20000) begin
      if (!s_axis_tvalid) begin
        if (wgap > 0) wgap--;
        else if (sent < nwords) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = 8'($urandom);
        end
      end
      m_axis_tready = throttle ? (rgap == 0) : 1'b1;
      chk_model(tag);
      do_push = s_axis_tvalid && (model_q.size() < DEPTH);
      do_pop  = m_axis_tready && (model_q.size() != 0);
      tick();
      cycles++;
      if (do_pop) begin
        void'(model_q.pop_front());
        rcvd++;
      end
      if (do_push) begin
        model_q.push_back(s_axis_tdata);
        sent++;
        s_axis_tvalid = 1'b0;
        wgap = throttle ? $urandom_range(0, 5) : 0;
      end
      if (throttle) begin
        if (rgap > 0) rgap--;
        else rgap = $urandom_range(0, 5);
      end
    end
    chk({tag, "_words_received"}, 32'(rcvd), 32'(nwords));
    if (!throttle) chk({tag, "_cycles"}, 32'(cycles), 32'(nwords + 1));
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b1, 8'h11};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 1'b1, 8'h11};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b1, 1'b1, 8'h11};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h22};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h33};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00};

    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    m_axis_tready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_sready", 32'(s_axis_tready), 32'd0);
      chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_count",  32'(count),         32'd0);
    end
    aresetn = 1'b1;
    tick();
    chk("release_sready", 32'(s_axis_tready), 32'd1);

    // Three pushes with the read side stalled, then drain.
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = vecs[i].tvalid;
      s_axis_tdata  = vecs[i].tdata;
      m_axis_tready = vecs[i].mready;
      tick();
      chk($sformatf("vec%0d_count", i),  32'(count),         32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_mvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].exp_mvalid));
      chk($sformatf("vec%0d_sready", i), 32'(s_axis_tready), 32'(vecs[i].exp_sready));
      if (vecs[i].exp_mvalid)
        chk($sformatf("vec%0d_mdata", i), 32'(m_axis_tdata), 32'(vecs[i].exp_mdata));
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;

    // Fill to full, hold a pending push, free one slot, then drain across the wrap.
    for (int i = 0; i < DEPTH; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(i);
      tick();
    end
    chk("full_count",  32'(count),         32'(DEPTH));
    chk("full_sready", 32'(s_axis_tready), 32'd0);
    s_axis_tdata = 8'h10;
    tick();
    chk("full_hold_count",  32'(count),         32'(DEPTH));
    chk("full_hold_sready", 32'(s_axis_tready), 32'd0);
    chk("full_head",        32'(m_axis_tdata),  32'h00);
    m_axis_tready = 1'b1;
    tick();
    chk("after_pop_count",  32'(count),         32'(DEPTH - 1));
    chk("after_pop_sready", 32'(s_axis_tready), 32'd1);
    chk("after_pop_head",   32'(m_axis_tdata),  32'h01);
    m_axis_tready = 1'b0;
    tick();
    chk("refill_count", 32'(count), 32'(DEPTH));
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("wrap_rd%0d", i), 32'(m_axis_tdata), 32'(i));
      tick();
    end
    chk("wrap_empty_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("wrap_empty_count",  32'(count),         32'd0);
    m_axis_tready = 1'b0;

    run_traffic("stream", 1000, 1'b0);
    run_traffic("throttle", 500, 1'b1);

    // Reset in the middle of traffic with both handshakes active.
    for (int i = 0; i < 7; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(8'h40 + i);
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd7);
    s_axis_tdata  = 8'h77;
    m_axis_tready = 1'b1;
    aresetn       = 1'b0;
    tick();
    chk("midrst_count",  32'(count),         32'd0);
    chk("midrst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_sready", 32'(s_axis_tready), 32'd0);
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    chk("post_rst_sready", 32'(s_axis_tready), 32'd1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hA5;
    tick();
    s_axis_tvalid = 1'b0;
    chk("post_rst_mvalid", 32'(m_axis_tvalid), 32'd1);
    chk("post_rst_mdata",  32'(m_axis_tdata),  32'hA5);
    chk("post_rst_count",  32'(count),         32'd1);
    m_axis_tready = 1'b1;
    tick();
    chk("post_rst_drained", 32'(m_axis_tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
